// File: rtl/axi_lite_buffer_slave_pkg.sv
// Shared constants and bundles for the buffer AXI4-Lite slave.
// Response codes match the buffer master's encoding.
package axi_lite_buffer_slave_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } wbeat_t;

endpackage

// File: rtl/axi_lite_buffer_slave_ram.sv
// Single-clock buffer RAM: byte-enable write port, synchronous read port.
// Read-before-write on address collisions; array is never reset.
module buffer_ram_bytewe
  import axi_lite_buffer_slave_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_buffer_slave.sv
// AXI4-Lite slave in front of a word-addressed buffer RAM.
// One outstanding write, one read every two cycles, all outputs registered.
module axi_lite_buffer_slave
  import axi_lite_buffer_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int IW  = ADDR_WIDTH - 2;
  localparam int RAW = $clog2(DEPTH_WORDS);

  logic                  aw_held;
  logic                  w_held;
  logic [IW-1:0]         aw_idx;
  wbeat_t                w_q;
  logic                  rd_ok;
  logic                  commit;
  logic                  wr_in;
  logic                  ar_hs;
  logic                  rd_in;
  logic [IW-1:0]         ar_idx;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  addr_lsb_unused;

  function automatic logic in_range(input logic [IW-1:0] idx);
    return 32'(idx) < 32'(DEPTH_WORDS);
  endfunction

  assign addr_lsb_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign s_awready = ~aw_held;
  assign s_wready  = ~w_held;
  assign s_arready = ~s_rvalid;

  assign commit = aw_held & w_held & ~s_bvalid;
  assign wr_in  = in_range(aw_idx);
  assign ar_idx = s_araddr[ADDR_WIDTH-1:2];
  assign ar_hs  = s_arvalid & ~s_rvalid;
  assign rd_in  = in_range(ar_idx);

  // Out-of-range reads never touch the RAM and return zero.
  assign s_rdata = rd_ok ? ram_q : '0;

  buffer_ram_bytewe #(
    .DEPTH (DEPTH_WORDS),
    .AW    (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (commit & wr_in),
    .waddr (aw_idx[RAW-1:0]),
    .wstrb (w_q.strb),
    .wdata (w_q.data),
    .re    (ar_hs & rd_in),
    .raddr (ar_idx[RAW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_q      <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_bvalid <= 1'b1;
      s_bresp  <= wr_in ? RESP_OKAY : RESP_SLVERR;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
    end else begin
      if (s_bvalid & s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (s_awvalid & ~aw_held) begin
        aw_held <= 1'b1;
        aw_idx  <= s_awaddr[ADDR_WIDTH-1:2];
      end
      if (s_wvalid & ~w_held) begin
        w_held <= 1'b1;
        w_q    <= '{data: s_wdata, strb: s_wstrb};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_rvalid <= 1'b0;
      s_rresp  <= RESP_OKAY;
      rd_ok    <= 1'b0;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rresp  <= rd_in ? RESP_OKAY : RESP_SLVERR;
      rd_ok    <= rd_in;
    end else if (s_rvalid & s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_buffer_slave.sv
// Bench for axi_lite_buffer_slave: two depths driven in lockstep,
// checked every cycle against a word-array model plus literal pins.
module tb_axi_lite_buffer_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [12:0] awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;
  logic [12:0] araddr;
  logic        arvalid;
  logic        rready;

  logic [1:0]  awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp [2];
  logic [1:0]  rresp [2];
  logic [31:0] rdata [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_buffer_slave #(.ADDR_WIDTH(13), .DEPTH_WORDS(2048)) u0 (
    .clk(clk), .rstn(rstn),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[0]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid),
    .s_wready(wready[0]),
    .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[0]),
    .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]),
    .s_rready(rready)
  );

  axi_lite_buffer_slave #(.ADDR_WIDTH(13), .DEPTH_WORDS(1024)) u1 (
    .clk(clk), .rstn(rstn),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[1]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid),
    .s_wready(wready[1]),
    .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[1]),
    .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]),
    .s_rready(rready)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding write, one held read response, word arrays.
  bit          m_awh [2];
  bit          m_wh  [2];
  bit          m_bv  [2];
  bit          m_rv  [2];
  logic [12:0] m_awa [2];
  logic [31:0] m_wd  [2];
  logic [3:0]  m_ws  [2];
  logic [1:0]  m_br  [2];
  logic [1:0]  m_rr  [2];
  logic [31:0] m_rd  [2];
  logic [31:0] mm    [2][2048];

  initial begin
    bit pa, pw, pb, pr;
    int dd, ridx, widx;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        dd = (k == 0) ? 2048 : 1024;
        pa = m_awh[k]; pw = m_wh[k]; pb = m_bv[k]; pr = m_rv[k];
        ridx = int'(araddr) / 4;
        widx = int'(m_awa[k]) / 4;
        if (!rstn) begin
          m_awh[k] = 0; m_wh[k] = 0; m_bv[k] = 0; m_rv[k] = 0;
          m_br[k] = 0; m_rr[k] = 0; m_rd[k] = 0;
        end else begin
          if (!pr && arvalid) begin
            m_rv[k] = 1;
            m_rd[k] = (ridx < dd) ? mm[k][ridx] : 32'h0;
            m_rr[k] = (ridx < dd) ? 2'b00 : 2'b10;
          end else if (pr && rready) begin
            m_rv[k] = 0;
          end
          if (pa && pw && !pb) begin
            if (widx < dd)
              for (int i = 0; i < 4; i++)
                if (m_ws[k][i]) mm[k][widx][8*i +: 8] = m_wd[k][8*i +: 8];
            m_br[k] = (widx < dd) ? 2'b00 : 2'b10;
            m_bv[k] = 1; m_awh[k] = 0; m_wh[k] = 0;
          end else begin
            if (pb && bready) m_bv[k] = 0;
            if (!pa && awvalid) begin m_awh[k] = 1; m_awa[k] = awaddr; end
            if (!pw && wvalid) begin
              m_wh[k] = 1; m_wd[k] = wdata; m_ws[k] = wstrb;
            end
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("awready%0d", k), 32'(awready[k]), 32'(!m_awh[k]));
        check($sformatf("wready%0d", k), 32'(wready[k]), 32'(!m_wh[k]));
        check($sformatf("arready%0d", k), 32'(arready[k]), 32'(!m_rv[k]));
        check($sformatf("bvalid%0d", k), 32'(bvalid[k]), 32'(m_bv[k]));
        check($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(m_rv[k]));
        if (m_bv[k])
          check($sformatf("bresp%0d", k), 32'(bresp[k]), 32'(m_br[k]));
        if (m_rv[k]) begin
          check($sformatf("rresp%0d", k), 32'(rresp[k]), 32'(m_rr[k]));
          check($sformatf("rdata%0d", k), rdata[k], m_rd[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic hs(input bit do_aw, input bit do_w);
    bit a_done, w_done, a_now, w_now;
    int t;
    a_done = !do_aw; w_done = !do_w; t = 0;
    awvalid = do_aw; wvalid = do_w;
    while (!(a_done && w_done) && t < 20) begin
      @(negedge clk);
      a_now = awvalid && awready[0];
      w_now = wvalid && wready[0];
      @(posedge clk); #2;
      if (a_now) begin awvalid = 0; a_done = 1; end
      if (w_now) begin wvalid = 0; w_done = 1; end
      t++;
    end
    if (!(a_done && w_done)) check("hs_timeout", 32'(t), 32'(0));
    awvalid = 0; wvalid = 0;
  endtask

  task automatic wr_both(input logic [12:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s;
    hs(1, 1);
  endtask

  task automatic wait_b(output logic [1:0] r0, output logic [1:0] r1);
    int t = 0;
    while (!bvalid[0] && t < 20) begin @(negedge clk); t++; end
    if (!bvalid[0]) check("b_timeout", 32'(t), 32'(0));
    r0 = bresp[0]; r1 = bresp[1];
    if (bready) tick();
  endtask

  task automatic rd(input logic [12:0] a, output logic [31:0] d0,
                    output logic [1:0] r0, output logic [31:0] d1,
                    output logic [1:0] r1);
    int t = 0;
    araddr = a; arvalid = 1;
    @(negedge clk);
    while (!arready[0] && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #2;
    arvalid = 0;
    @(negedge clk);
    check("r_one_edge", 32'(rvalid[0]), 32'(1));
    d0 = rdata[0]; r0 = rresp[0]; d1 = rdata[1]; r1 = rresp[1];
    if (rready) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r0, r1;
    logic [31:0] d0, d1;
    rstn = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 1; araddr = 0; arvalid = 0; rready = 1;
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'(2'b11));
    check("rst_wready", 32'(wready), 32'(2'b11));
    check("rst_bvalid", 32'(bvalid), 32'(0));
    check("rst_rvalid", 32'(rvalid), 32'(0));
    check("rst_rdata", rdata[0], 32'h0);
    tick(); tick();
    rstn = 1;
    tick();

    wr_both(13'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("b_not_yet", 32'(bvalid[0]), 32'(0));
    @(negedge clk);
    check("b_two_edges", 32'(bvalid[0]), 32'(1));
    wait_b(r0, r1);
    check("t1_bresp", 32'(r0), 32'(2'b00));
    rd(13'h010, d0, r0, d1, r1);
    check("t1_rdata", d0, 32'hDEADBEEF);
    check("t1_rresp", 32'(r0), 32'(2'b00));

    wdata = 32'h11223344; wstrb = 4'b0101;
    hs(0, 1);
    repeat (3) tick();
    awaddr = 13'h010;
    hs(1, 0);
    wait_b(r0, r1);
    rd(13'h010, d0, r0, d1, r1);
    check("t2_strobe", d0, 32'hDE22BE44);

    bready = 0;
    wr_both(13'h030, 32'hAAAA0000, 4'hF);
    wait_b(r0, r1);
    tick();
    wr_both(13'h030, 32'h5555AAAA, 4'hF);
    repeat (5) tick();
    check("t3_b_held", 32'(bvalid[0]), 32'(1));
    rd(13'h030, d0, r0, d1, r1);
    check("t3_no_commit", d0, 32'hAAAA0000);
    bready = 1;
    tick();
    @(negedge clk);
    check("t3_gap", 32'(bvalid[0]), 32'(0));
    wait_b(r0, r1);
    check("t3_bresp2", 32'(r0), 32'(2'b00));
    rd(13'h030, d0, r0, d1, r1);
    check("t3_second", d0, 32'h5555AAAA);

    wr_both(13'h000, 32'h0BADCAFE, 4'hF);
    wait_b(r0, r1);
    wr_both(13'h1FFC, 32'hCAFEF00D, 4'hF);
    wait_b(r0, r1);
    check("t4_last_ok", 32'(r0), 32'(2'b00));
    check("t4_last_err", 32'(r1), 32'(2'b10));
    wr_both(13'h1000, 32'h12345678, 4'hF);
    wait_b(r0, r1);
    check("t4_oor_ok", 32'(r0), 32'(2'b00));
    check("t4_oor_err", 32'(r1), 32'(2'b10));
    rd(13'h000, d0, r0, d1, r1);
    check("t4_no_alias", d1, 32'h0BADCAFE);
    rd(13'h1000, d0, r0, d1, r1);
    check("t4_rd0", d0, 32'h12345678);
    check("t4_rd1", d1, 32'h0);
    check("t4_rresp1", 32'(r1), 32'(2'b10));
    rd(13'h1FFC, d0, r0, d1, r1);
    check("t4_last_rd", d0, 32'hCAFEF00D);

    wr_both(13'h020, 32'h00000005, 4'hF);
    wait_b(r0, r1);
    wr_both(13'h020, 32'h00000007, 4'hF);
    araddr = 13'h020; arvalid = 1;
    tick();
    arvalid = 0;
    @(negedge clk);
    check("t5_old", rdata[0], 32'h00000005);
    repeat (3) tick();
    rd(13'h020, d0, r0, d1, r1);
    check("t5_new", d0, 32'h00000007);

    awaddr = 13'h040;
    hs(1, 0);
    rready = 0;
    araddr = 13'h020; arvalid = 1;
    tick();
    arvalid = 0;
    check("t6_held", 32'(awready[0]), 32'(0));
    check("t6_rv", 32'(rvalid[0]), 32'(1));
    rstn = 0;
    #1;
    check("t6_awready", 32'(awready), 32'(2'b11));
    check("t6_wready", 32'(wready), 32'(2'b11));
    check("t6_rvalid", 32'(rvalid), 32'(0));
    check("t6_rdata", rdata[0], 32'h0);
    tick();
    rstn = 1; rready = 1;
    tick();
    wdata = 32'h99999999; wstrb = 4'hF;
    hs(0, 1);
    repeat (4) tick();
    check("t6_no_commit", 32'(bvalid[0]), 32'(0));
    check("t6_aw_free", 32'(awready[0]), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
